// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage_lsu_if                                                |
// | Purpose  : Bundles the EX/MEM input record, the data-memory request /      |
// |            response port, and the MEM/WB writeback + forwarding record.    |
// | Modports : slave  - the load/store unit (consumes in_*, drives dmem_req    |
// |                     side, drives out_* / fwd_*).                           |
// |            master - the surrounding pipeline / memory / testbench.         |
// | Params   : XLEN (32 or 64), MASKW = XLEN/8 (derived).                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_stage_lsu_if #(
  parameter int XLEN  = 32,
  parameter int MASKW = XLEN / 8
);
  // EX/MEM side
  logic             in_valid;
  logic             in_ready;
  logic             in_load;
  logic             in_store;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_addr;
  logic [XLEN-1:0]  in_wdata;
  logic [XLEN-1:0]  in_rd_wdata;
  logic [4:0]       in_rd_addr;
  // data memory
  logic             dmem_req;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [MASKW-1:0] dmem_wmask;
  logic [MASKW-1:0] dmem_rmask;
  logic [XLEN-1:0]  dmem_wdata;
  logic             dmem_resp;
  logic [XLEN-1:0]  dmem_rdata;
  // MEM/WB side
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rd_addr;
  logic [XLEN-1:0]  out_rd_wdata;
  logic             out_regf_we;
  logic             out_trap;
  logic             fwd_valid;
  logic [XLEN-1:0]  fwd_data;

  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
           in_rd_wdata, in_rd_addr, dmem_resp, dmem_rdata, out_ready,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_rmask,
           dmem_wdata, out_valid, out_rd_addr, out_rd_wdata, out_regf_we,
           out_trap, fwd_valid, fwd_data
  );

  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
           in_rd_wdata, in_rd_addr, dmem_resp, dmem_rdata, out_ready,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_rmask,
           dmem_wdata, out_valid, out_rd_addr, out_rd_wdata, out_regf_we,
           out_trap, fwd_valid, fwd_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage_lsu                                                   |
// | Purpose  : Load/store unit with built-in MEM/WB register. Accepts one      |
// |            EX/MEM record per handshake, issues a single-pulse request to   |
// |            a variable-latency data memory, aligns store lanes, extracts    |
// |            and sign/zero-extends load data, and presents a registered      |
// |            writeback record plus forwarding value.                         |
// | Ports    : clk, rst (async, active-high), bus (mem_stage_lsu_if.slave).    |
// | Params   : XLEN (32/64), MASKW = XLEN/8 (derived).                         |
// | Macro    : MEM_STAGE_LSU_MISALIGN_TRAP_EN - misaligned accesses trap       |
// |            instead of being issued with the offset rounded down.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_stage_lsu #(
  parameter int XLEN  = 32,
  parameter int MASKW = XLEN / 8
) (
  input wire             clk,
  input wire             rst,
  mem_stage_lsu_if.slave bus
);

  localparam int C_OFFW = $clog2(MASKW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_dmem_req;
  logic               r_dmem_we;
  logic [XLEN-1:0]    r_dmem_addr;
  logic [MASKW-1:0]   r_dmem_wmask;
  logic [MASKW-1:0]   r_dmem_rmask;
  logic [XLEN-1:0]    r_dmem_wdata;
  logic               r_out_valid;
  logic [4:0]         r_out_rd_addr;
  logic [XLEN-1:0]    r_out_rd_wdata;
  logic               r_out_regf_we;
  // context held across ISSUE/WAIT for load extraction
  logic               r_load;
  logic               r_rd_nz;
  logic [4:0]         r_rd_addr;
  logic [C_OFFW-1:0]  r_off;
  logic [1:0]         r_size_log;
  logic               r_unsigned;

  // ---------------------------------------------------------------- decode
  logic [1:0]         w_size_log;
  logic [3:0]         w_nbytes;
  logic [C_OFFW-1:0]  w_off_raw;
  logic [C_OFFW-1:0]  w_off;
  logic [MASKW-1:0]   w_mask;
  logic [XLEN-1:0]    w_aligned_addr;
  logic [XLEN-1:0]    w_store_data;
  logic               w_mem_op;
  logic               w_is_store;
  logic               w_rd_nz;
  logic               w_trap;

  always_comb begin
    // Doubleword encodings do not exist on RV32; they collapse to word size.
    w_size_log = bus.in_funct3[1:0];
    if (XLEN == 32 && bus.in_funct3[1:0] == 2'b11) begin
      w_size_log = 2'b10;
    end
    w_nbytes       = 4'd1 << w_size_log;
    w_off_raw      = bus.in_addr[C_OFFW-1:0];
    // Offset rounded down to a multiple of the access size.
    w_off          = w_off_raw & ({C_OFFW{1'b1}} << w_size_log);
    w_mask         = ~({MASKW{1'b1}} << w_nbytes) << w_off;
    w_aligned_addr = {bus.in_addr[XLEN-1:C_OFFW], {C_OFFW{1'b0}}};
    w_store_data   = bus.in_wdata << {w_off, 3'b000};
    w_mem_op       = bus.in_load | bus.in_store;
    // A record flagged as both load and store is treated as a load.
    w_is_store     = bus.in_store & ~bus.in_load;
    w_rd_nz        = (bus.in_rd_addr != 5'd0);
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    w_trap = w_mem_op && ((w_off_raw & ~({C_OFFW{1'b1}} << w_size_log)) != '0);
`else
    w_trap = 1'b0;
`endif
  end

  // ------------------------------------------------------- load extraction
  logic [3:0]         w_ld_nbytes;
  logic [XLEN-1:0]    w_shifted;
  logic [XLEN-1:0]    w_lmask;
  logic [XLEN-1:0]    w_load_val;
  logic               w_sign;

  always_comb begin
    w_ld_nbytes = 4'd1 << r_size_log;
    w_shifted   = bus.dmem_rdata >> {r_off, 3'b000};
    // A shift by the full width yields zero, so a full-width access gets an all-ones mask.
    w_lmask     = ~({XLEN{1'b1}} << {w_ld_nbytes, 3'b000});
    case (r_size_log)
      2'd0:    w_sign = w_shifted[7];
      2'd1:    w_sign = w_shifted[15];
      2'd2:    w_sign = w_shifted[31];
      default: w_sign = w_shifted[XLEN-1];
    endcase
    w_load_val = w_shifted & w_lmask;
    if (!r_unsigned && w_sign) begin
      w_load_val = w_load_val | ~w_lmask;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_wmask   <= '0;
      r_dmem_rmask   <= '0;
      r_dmem_wdata   <= '0;
      r_out_valid    <= 1'b0;
      r_out_rd_addr  <= 5'd0;
      r_out_rd_wdata <= '0;
      r_out_regf_we  <= 1'b0;
      r_load         <= 1'b0;
      r_rd_nz        <= 1'b0;
      r_rd_addr      <= 5'd0;
      r_off          <= '0;
      r_size_log     <= 2'd0;
      r_unsigned     <= 1'b0;
    end else begin
      r_dmem_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_load     <= bus.in_load;
            r_rd_nz    <= w_rd_nz;
            r_rd_addr  <= bus.in_rd_addr;
            r_off      <= w_off;
            r_size_log <= w_size_log;
            r_unsigned <= bus.in_funct3[2];
            if (w_mem_op && !w_trap) begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= w_is_store;
              r_dmem_addr  <= w_aligned_addr;
              r_dmem_wmask <= w_is_store ? w_mask : '0;
              r_dmem_rmask <= w_is_store ? '0 : w_mask;
              r_dmem_wdata <= w_is_store ? w_store_data : '0;
              r_state      <= S_ISSUE;
            end else begin
              // Pass-through, or a trapped access that never reaches memory.
              r_out_valid    <= 1'b1;
              r_out_rd_addr  <= bus.in_rd_addr;
              r_out_rd_wdata <= (!w_mem_op && w_rd_nz) ? bus.in_rd_wdata : '0;
              r_out_regf_we  <= !w_mem_op && w_rd_nz;
              r_state        <= S_RESULT;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.dmem_resp) begin
            r_out_valid    <= 1'b1;
            r_out_rd_addr  <= r_rd_addr;
            r_out_rd_wdata <= (r_load && r_rd_nz) ? w_load_val : '0;
            r_out_regf_we  <= r_load && r_rd_nz;
            r_state        <= S_RESULT;
          end
        end
        default: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
  logic r_out_trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_trap <= 1'b0;
    end else if (r_state == S_IDLE && bus.in_valid) begin
      r_out_trap <= w_trap;
    end else if (r_state == S_RESULT && bus.out_ready) begin
      r_out_trap <= 1'b0;
    end
  end

  assign bus.out_trap = r_out_trap;
`else
  assign bus.out_trap = 1'b0;
`endif

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.dmem_req     = r_dmem_req;
  assign bus.dmem_we      = r_dmem_we;
  assign bus.dmem_addr    = r_dmem_addr;
  assign bus.dmem_wmask   = r_dmem_wmask;
  assign bus.dmem_rmask   = r_dmem_rmask;
  assign bus.dmem_wdata   = r_dmem_wdata;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_rd_addr  = r_out_rd_addr;
  assign bus.out_rd_wdata = r_out_rd_wdata;
  assign bus.out_regf_we  = r_out_regf_we;
  assign bus.fwd_valid    = r_out_valid & r_out_regf_we;
  assign bus.fwd_data     = r_out_rd_wdata;

endmodule
`default_nettype wire
